// File: rtl/operand2_stage.sv
// Operand-2 stage: selects rs2 or the sign-extended simm13 as the ALU second
// operand and queues it, with rd/op3/i, in a small circular FIFO toward the ALU.
package operand2_stage_pkg;

  typedef struct packed {
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [5:0]  op3;
    logic        is_imm;
  } entry_t;

endpackage

module operand2_stage
  import operand2_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic [31:0] Rs2_val,
  input  logic        Valid_in,
  output logic        Ready_in,
  output logic [12:0] Simm13,
  input  logic [31:0] Imm_ext,
  output logic        Valid_out,
  input  logic        Ready_out,
  output logic [31:0] Op2,
  output logic [4:0]  Rd_out,
  output logic [5:0]  Op3_out,
  output logic        Is_imm,
  input  logic        Flush,
  output logic [2:0]  Count
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = 3;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_nxt_c;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic [CNT_W-1:0] count_q;
  logic             push_c;
  logic             pop_c;
  entry_t           new_entry_c;
  entry_t           head_c;
  logic             unused_instr;

  // Sign extender sits outside this block; its result returns on Imm_ext.
  assign Simm13 = Instr[12:0];

  // Handshakes depend only on registered occupancy, never on Ready_out.
  assign Ready_in  = (count_q < FULL_CNT);
  assign Valid_out = (count_q != '0);
  assign push_c    = Valid_in & Ready_in & ~Flush;
  assign pop_c     = Valid_out & Ready_out & ~Flush;

  always_comb begin
    new_entry_c        = '0;
    new_entry_c.op2    = Instr[13] ? Imm_ext : Rs2_val;
    new_entry_c.rd     = Instr[29:25];
    new_entry_c.op3    = Instr[24:19];
    new_entry_c.is_imm = Instr[13];
  end

  assign wr_ptr_nxt_c = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
  assign rd_ptr_nxt_c = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

  // Storage is cleared on reset so the head outputs read zero until the first push.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= new_entry_c;
        wr_ptr_q        <= wr_ptr_nxt_c;
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_nxt_c;
      end
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Head entry is never overwritten while it is presented: a push can only
  // target the head slot when the FIFO is empty.
  assign head_c  = mem_q[rd_ptr_q];
  assign Op2     = head_c.op2;
  assign Rd_out  = head_c.rd;
  assign Op3_out = head_c.op3;
  assign Is_imm  = head_c.is_imm;
  assign Count   = count_q;

  assign unused_instr = ^{Instr[31:30], Instr[18:14]};

endmodule

// File: tb/tb_operand2_stage.sv
// Scoreboard bench for operand2_stage: directed scenarios plus random traffic
// checked against a queue model of the operand FIFO.
module tb_operand2_stage;

  localparam int unsigned DEPTH = 2;

  logic        Clk       = 1'b0;
  logic        Reset_n   = 1'b1;
  logic [31:0] Instr     = '0;
  logic [31:0] Rs2_val   = '0;
  logic [31:0] Imm_ext   = '0;
  logic        Valid_in  = 1'b0;
  logic        Ready_out = 1'b0;
  logic        Flush     = 1'b0;
  logic        Ready_in;
  logic [12:0] Simm13;
  logic        Valid_out;
  logic [31:0] Op2;
  logic [4:0]  Rd_out;
  logic [5:0]  Op3_out;
  logic        Is_imm;
  logic [2:0]  Count;

  operand2_stage #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Rs2_val(Rs2_val),
    .Valid_in(Valid_in), .Ready_in(Ready_in), .Simm13(Simm13),
    .Imm_ext(Imm_ext), .Valid_out(Valid_out), .Ready_out(Ready_out),
    .Op2(Op2), .Rd_out(Rd_out), .Op3_out(Op3_out), .Is_imm(Is_imm),
    .Flush(Flush), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Every accepted item ever issued; live contents are exp_q[rd_idx .. size-1].
  logic [43:0] exp_q [$];
  int unsigned base_idx = 0;
  int unsigned rd_idx   = 0;
  int unsigned pre_occ  = 0;
  int unsigned occ      = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] sext13(input logic [12:0] s);
    return {{19{s[12]}}, s};
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [5:0] op3,
                                           input logic i, input logic [12:0] simm);
    logic [6:0] junk;
    junk = 7'($urandom);
    return {junk[6:5], rd, op3, junk[4:0], i, simm};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp_v);
    end
  endtask

  // Issue side: record what the FIFO must accept at each edge.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n || Flush) begin
      base_idx = exp_q.size();
    end else if (Valid_in && pre_occ < DEPTH) begin
      exp_q.push_back({(Instr[13] ? Imm_ext : Rs2_val), Instr[29:25], Instr[24:19], Instr[13]});
    end
  end

  // Monitor: compare occupancy, handshakes and head against the model.
  always begin
    @(negedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      #1;
      check("rst_count",    64'(Count),     64'd0);
      check("rst_valid",    64'(Valid_out), 64'd0);
      check("rst_ready_in", 64'(Ready_in),  64'd1);
      check("rst_head",     64'({Op2, Rd_out, Op3_out, Is_imm}), 64'd0);
      pre_occ = 0;
    end else begin
      if (rd_idx < base_idx) rd_idx = base_idx;
      occ = 32'(exp_q.size()) - rd_idx;
      check("count",     64'(Count),     64'(occ));
      check("valid_out", 64'(Valid_out), 64'(occ != 0));
      check("ready_in",  64'(Ready_in),  64'(occ < DEPTH));
      check("simm13",    64'(Simm13),    64'(Instr[12:0]));
      if (occ != 0) begin
        check("head", 64'({Op2, Rd_out, Op3_out, Is_imm}), 64'(exp_q[rd_idx]));
      end
      pre_occ = occ;
      if (occ != 0 && Ready_out && !Flush) rd_idx++;
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs2,
                      input logic rdy, input logic fl);
    Valid_in  = v;
    Instr     = ins;
    Rs2_val   = rs2;
    Imm_ext   = sext13(ins[12:0]);
    Ready_out = rdy;
    Flush     = fl;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_rand(input logic rdy);
    step(1'b1, $urandom, $urandom, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, $urandom, $urandom, rdy, 1'b0);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    #3 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Immediate operand: simm13 = 0x1001 sign-extends to 0xFFFFF001.
    step(1'b1, mk_instr(5'd3, 6'h02, 1'b1, 13'h1001), 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1'b1);
    // Register operand selected even though Imm_ext is non-zero.
    step(1'b1, mk_instr(5'd7, 6'h04, 1'b0, 13'h0EE3), 32'h12345678, 1'b0, 1'b0);
    idle(1'b1);

    // Backpressure: third push refused while full, then in-order drain.
    repeat (3) push_rand(1'b0);
    repeat (3) idle(1'b1);

    // Full FIFO streaming: pointers wrap while occupancy holds at DEPTH.
    repeat (2) push_rand(1'b0);
    repeat (6) push_rand(1'b1);
    repeat (3) idle(1'b1);

    // Flush while full and while a push is offered.
    repeat (2) push_rand(1'b0);
    step(1'b1, $urandom, $urandom, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Asynchronous reset mid-cycle with one entry held.
    push_rand(1'b0);
    #2 Reset_n = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    push_rand(1'b0);
    idle(1'b1);

    // Random traffic with occasional flushes.
    repeat (400) begin
      step(1'b1 && ($urandom_range(3) != 0), $urandom, $urandom,
           ($urandom_range(2) != 0), ($urandom_range(39) == 0));
    end
    repeat (6) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand2_stage.md
OPERAND2_STAGE -- requirements
Module: operand2_stage

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low, with ports named Clk and Reset_n.
REQ-002 Parameter DEPTH, default 2: number of entries in the output buffer; legal values are 2 and 4.
REQ-003 Port Clk, input, 1 bit: rising-edge clock.
REQ-004 Port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port Instr, input, 32 bits: decoded instruction word. Fields: Instr[29:25]=rd, Instr[24:19]=op3, Instr[13]=i, Instr[12:0]=simm13.
REQ-006 Port Rs2_val, input, 32 bits: register-file read value for rs2.
REQ-007 Port Valid_in, input, 1 bit: Instr and Rs2_val are valid this cycle.
REQ-008 Port Ready_in, output, 1 bit: the stage can accept an input this cycle.
REQ-009 Port Simm13, output, 13 bits: equals Instr[12:0] combinationally; drives the 13-to-32 sign extender Entrada.
REQ-010 Port Imm_ext, input, 32 bits: sign extender Salida, returned in the same cycle.
REQ-011 Port Valid_out, output, 1 bit: the head entry is valid.
REQ-012 Port Ready_out, input, 1 bit: downstream (ALU) accepts the head entry.
REQ-013 Port Op2, output, 32 bits: second operand of the head entry.
REQ-014 Port Rd_out, output, 5 bits: rd of the head entry.
REQ-015 Port Op3_out, output, 6 bits: op3 of the head entry.
REQ-016 Port Is_imm, output, 1 bit: i bit of the head entry.
REQ-017 Port Flush, input, 1 bit: synchronous flush of all entries.
REQ-018 Port Count, output, 3 bits: current occupancy, 0..DEPTH.

Function
REQ-019 Push SHALL occur when Valid_in=1 and Ready_in=1 and Flush=0; pop SHALL occur when Valid_out=1 and Ready_out=1 and Flush=0.
REQ-020 On push, the stored operand SHALL be Imm_ext when Instr[13]=1, otherwise Rs2_val; rd, op3 and i are stored alongside it.
REQ-021 The buffer SHALL be a circular FIFO with separate write and read pointers that wrap from DEPTH-1 to 0.
REQ-022 Latency SHALL be 1 cycle: an entry pushed at edge N appears on the outputs after edge N when the FIFO was empty; there is no combinational input-to-output path.
REQ-023 Ready_in SHALL be (Count < DEPTH), registered-derived only, with no dependence on Ready_out.
REQ-024 Simultaneous push and pop SHALL leave Count unchanged; both pointers advance.
REQ-025 Pop while empty SHALL be impossible, because Valid_out=0 when Count=0.
REQ-026 Push while full SHALL be impossible, because Ready_in=0; Valid_in is ignored.
REQ-027 Flush=1 SHALL, at the next edge, set Count=0 and both pointers to 0, ignoring any push or pop in that cycle.
REQ-028 Valid_out SHALL be (Count != 0); Op2, Rd_out, Op3_out and Is_imm SHALL show the head entry and are don't-care when Valid_out=0.
REQ-029 Head outputs SHALL hold stable while Valid_out=1 and Ready_out=0.
REQ-030 Count SHALL never exceed DEPTH and never underflow.

Reset
REQ-031 Reset_n=0 SHALL immediately force Count=0, pointers=0, Valid_out=0, Ready_in=1, and Op2/Rd_out/Op3_out/Is_imm=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; the first push after Reset_n rises is accepted at the first rising edge.

Verification
REQ-033 Reset, then push Instr with i=1, simm13=13'h1001 (Imm_ext=32'hFFFFF001) -> next cycle Valid_out=1, Op2=32'hFFFFF001, Is_imm=1, Count=1.
REQ-034 Push i=0 with Rs2_val=32'h12345678 and Imm_ext=32'h00000EE3 -> Op2=32'h12345678, Is_imm=0.
REQ-035 Hold Ready_out=0 and push 3 items with DEPTH=2 -> Count=2, Ready_in=0, third item not accepted; then Ready_out=1 -> items pop in order.
REQ-036 Full FIFO with simultaneous push and pop over 6 cycles -> Count stays 2, in-order output, pointers wrap correctly.
REQ-037 Flush with Count=2 together with Valid_in=1 -> next cycle Count=0, Valid_out=0.
REQ-038 Reset_n pulsed low asynchronously mid-cycle with Count=1 -> Valid_out=0 immediately, Op2=0.
